// File: rtl/clip_sched.sv
// clip_sched: round-robin scheduler sharing one registered saturating clip stage among NCH channels.
// Defining CLIP_SCHED_SAT_CNT_EN adds per-channel 8-bit saturation counters (sat_clr / sat_cnt).
module clip_sched #(
  parameter int NCH    = 4,
  parameter int BW_IN  = 5,
  parameter int BW_OUT = 3,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req_valid,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH*BW_IN-1:0] req_data,
  input  logic [NCH-1:0]       req_in_signed,
  input  logic [NCH-1:0]       req_out_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW_OUT-1:0]    out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_clipped
`ifdef CLIP_SCHED_SAT_CNT_EN
  ,
  input  logic                 sat_clr,
  output logic [NCH*8-1:0]     sat_cnt
`endif
);

  localparam int UMAX = (1 << BW_OUT) - 1;
  localparam int SMAX = (1 << (BW_OUT - 1)) - 1;
  localparam int SMIN = -(1 << (BW_OUT - 1));

  function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= NCH) ? (s - NCH) : s;
    return CW'(s);
  endfunction

  // Result is {clipped, data}; the sample is widened to int so both signednesses compare uniformly.
  function automatic logic [BW_OUT:0] clip(input logic [BW_IN-1:0] smp, input logic in_s,
                                           input logic out_s);
    int v;
    int lo;
    int hi;
    v  = in_s  ? int'($signed(smp)) : int'(smp);
    lo = out_s ? SMIN : 0;
    hi = out_s ? SMAX : UMAX;
    if (v < lo) begin
      return {1'b1, BW_OUT'(lo)};
    end else if (v > hi) begin
      return {1'b1, BW_OUT'(hi)};
    end else begin
      return {1'b0, smp[BW_OUT-1:0]};
    end
  endfunction

  logic [CW-1:0]     r_ptr;
  logic              r_out_valid;
  logic [BW_OUT-1:0] r_out_data;
  logic [CW-1:0]     r_out_ch;
  logic              r_out_clipped;

  logic              w_gnt_found;
  logic [CW-1:0]     w_gnt_ch;
  logic              w_can_load;
  logic              w_xfer;
  logic [BW_IN-1:0]  w_sel_data;
  logic [BW_OUT:0]   w_clip_res;

  // Walk offsets high to low so the smallest offset from r_ptr wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_ch    = r_ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      w_gnt_ch    = req_valid[rr_index(r_ptr, i)] ? rr_index(r_ptr, i) : w_gnt_ch;
      w_gnt_found = w_gnt_found | req_valid[rr_index(r_ptr, i)];
    end
  end

  assign w_can_load = ~r_out_valid | out_ready;
  assign w_xfer     = rst_n & w_can_load & w_gnt_found;
  assign req_ready  = w_xfer ? (NCH'(1'b1) << w_gnt_ch) : NCH'(1'b0);
  assign w_sel_data = req_data[w_gnt_ch*BW_IN +: BW_IN];
  assign w_clip_res = clip(w_sel_data, req_in_signed[w_gnt_ch], req_out_signed[w_gnt_ch]);

  // Output stage: a load may replace a result draining in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_ch      <= '0;
      r_out_clipped <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= w_clip_res[BW_OUT-1:0];
      r_out_ch      <= w_gnt_ch;
      r_out_clipped <= w_clip_res[BW_OUT];
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end else begin
      r_out_valid   <= r_out_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= rr_index(w_gnt_ch, 1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_ch      = r_out_ch;
  assign out_clipped = r_out_clipped;

`ifdef CLIP_SCHED_SAT_CNT_EN
  logic [7:0] r_sat_cnt [NCH];

  // Clear has priority over counting; counts stick at 255.
  always_ff @(posedge clk) begin
    if (!rst_n || sat_clr) begin
      for (int k = 0; k < NCH; k++) begin
        r_sat_cnt[k] <= 8'd0;
      end
    end else if (w_xfer && w_clip_res[BW_OUT] && (r_sat_cnt[w_gnt_ch] != 8'hFF)) begin
      r_sat_cnt[w_gnt_ch] <= r_sat_cnt[w_gnt_ch] + 8'd1;
    end else begin
      r_sat_cnt[w_gnt_ch] <= r_sat_cnt[w_gnt_ch];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_sat_out
    assign sat_cnt[g*8 +: 8] = r_sat_cnt[g];
  end
`endif

endmodule

// File: tb/tb_clip_sched.sv
// Self-checking bench for clip_sched: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_clip_sched;
  localparam int NCH    = 4;
  localparam int BW_IN  = 5;
  localparam int BW_OUT = 3;
  localparam int CW     = 2;
  localparam int DW     = NCH * BW_IN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [DW-1:0]     req_data;
  logic [NCH-1:0]    req_in_signed;
  logic [NCH-1:0]    req_out_signed;
  logic              out_valid;
  logic              out_ready;
  logic [BW_OUT-1:0] out_data;
  logic [CW-1:0]     out_ch;
  logic              out_clipped;
`ifdef CLIP_SCHED_SAT_CNT_EN
  logic              sat_clr;
  logic [NCH*8-1:0]  sat_cnt;
`endif

  always #5 clk = ~clk;

  clip_sched #(.NCH(NCH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_in_signed(req_in_signed), .req_out_signed(req_out_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_clipped(out_clipped)
`ifdef CLIP_SCHED_SAT_CNT_EN
    , .sat_clr(sat_clr), .sat_cnt(sat_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ptr   = 0;
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_ch    = 0;
  bit m_clip  = 1'b0;
  int m_sat [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Saturating clip computed from the numeric ranges.
  function automatic int ref_clip(input int k, output bit clp);
    logic [BW_IN-1:0] s;
    int v, lo, hi, r;
    s = req_data[k*BW_IN +: BW_IN];
    v = req_in_signed[k] ? int'($signed(s)) : int'(s);
    if (req_out_signed[k]) begin
      lo = -(2 ** (BW_OUT - 1));
      hi = 2 ** (BW_OUT - 1) - 1;
    end else begin
      lo = 0;
      hi = 2 ** BW_OUT - 1;
    end
    clp = (v < lo) || (v > hi);
    r = (v < lo) ? lo : ((v > hi) ? hi : v);
    return r & (2 ** BW_OUT - 1);
  endfunction

  // One clock: check the handshake before the edge, the registered outputs after it.
  task automatic tick();
    int g;
    logic [NCH-1:0] exp_rdy;
    bit xfer;
    bit clp;
    int val;
    #1;
    g = -1;
    for (int i = 0; i < NCH; i++) begin
      if (g < 0 && req_valid[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
    end
    xfer = rst_n && (g >= 0) && (!m_valid || out_ready);
    exp_rdy = '0;
    if (xfer) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    clp = 1'b0;
    val = xfer ? ref_clip(g, clp) : 0;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 1'b0; m_data = 0; m_ch = 0; m_clip = 1'b0; m_ptr = 0;
    end else if (xfer) begin
      m_valid = 1'b1; m_data = val; m_ch = g; m_clip = clp; m_ptr = (g + 1) % NCH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), m_data);
    chk("out_ch", 32'(out_ch), m_ch);
    chk("out_clipped", 32'(out_clipped), 32'(m_clip));
`ifdef CLIP_SCHED_SAT_CNT_EN
    for (int k = 0; k < NCH; k++) begin
      if (!rst_n || sat_clr) m_sat[k] = 0;
      else if (xfer && clp && k == g && m_sat[k] < 255) m_sat[k] = m_sat[k] + 1;
      chk("sat_cnt", 32'(sat_cnt[k*8 +: 8]), m_sat[k]);
    end
`endif
  endtask

  task automatic randomize_data();
    req_data       = DW'($urandom);
    req_in_signed  = NCH'($urandom);
    req_out_signed = NCH'($urandom);
  endtask

  // Single-channel request for one cycle.
  task automatic send(input int k, input logic [BW_IN-1:0] d, input bit ins, input bit outs);
    randomize_data();
    req_valid = '0;
    req_valid[k] = 1'b1;
    req_data[k*BW_IN +: BW_IN] = d;
    req_in_signed[k]  = ins;
    req_out_signed[k] = outs;
    tick();
    req_valid = '0;
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) m_sat[k] = 0;
    rst_n = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    req_data = '0;
    req_in_signed = '0;
    req_out_signed = '0;
`ifdef CLIP_SCHED_SAT_CNT_EN
    sat_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // Clip corner cases, one channel each
    send(0, 5'b10000, 1'b1, 1'b1);
    chk("c0_data", 32'(out_data), 32'd4);
    chk("c0_clip", 32'(out_clipped), 32'd1);
    chk("c0_ch", 32'(out_ch), 32'd0);
    send(1, 5'd9, 1'b0, 1'b0);
    chk("c1_data", 32'(out_data), 32'd7);
    chk("c1_clip", 32'(out_clipped), 32'd1);
    send(2, 5'b11101, 1'b1, 1'b1);
    chk("c2_data", 32'(out_data), 32'd5);
    chk("c2_clip", 32'(out_clipped), 32'd0);
    send(3, 5'b11101, 1'b1, 1'b0);
    chk("c3_data", 32'(out_data), 32'd0);
    chk("c3_clip", 32'(out_clipped), 32'd1);
    tick();

    // All channels requesting from reset: grants rotate 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      tick();
      chk("rr_ch", 32'(out_ch), i % NCH);
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure for three cycles, then release: next grant is channel 1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      tick();
      chk("bp_hold_ch", 32'(out_ch), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_ch", 32'(out_ch), 32'd1);

    // Reset while a result is held
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst_drop_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rst_ptr_ch", 32'(out_ch), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      req_valid = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef CLIP_SCHED_SAT_CNT_EN
      sat_clr   = ($urandom_range(0, 39) == 0);
`endif
      randomize_data();
      tick();
    end
    rst_n = 1'b1;
    out_ready = 1'b1;

`ifdef CLIP_SCHED_SAT_CNT_EN
    sat_clr = 1'b1;
    req_valid = '0;
    tick();
    sat_clr = 1'b0;
    for (int n = 0; n < 300; n++) send(2, 5'd31, 1'b0, 1'b0);
    chk("sat_ch2_max", 32'(sat_cnt[16 +: 8]), 32'd255);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_ch2_clr", 32'(sat_cnt[16 +: 8]), 32'd0);
`endif

    req_valid = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
